// File: rtl/gb_oam_dma_engine.sv
// OAM DMA engine: decodes CPU writes to the DMA register, waits a start delay,
// then copies XFER_LEN bytes from {src_page,idx} into OAM, one byte per
// CYCLES_PER_BYTE T-cycles. A register write during a run restarts it.
// Ports:
//   clk, reset                 T-clock, async active-high reset
//   addr, wr_en, data_i        CPU write bus
//   data_o                     DMA register readback
//   dma_start, dma_active      start-delay phase / bus+OAM ownership
//   dma_rd_req, dma_rd_addr    system read port, dma_rd_data returns source byte
//   oam_wr_en/idx/data         OAM byte write port
module gb_oam_dma_engine #(
  parameter logic [15:0] REG_ADDR        = 16'hFF46,
  parameter int unsigned XFER_LEN        = 160,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 1,
  parameter bit          MIRROR_ECHO     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        wr_en,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        dma_start,
  output logic        dma_active,
  output logic        dma_rd_req,
  output logic [15:0] dma_rd_addr,
  input  logic [7:0]  dma_rd_data,
  output logic        oam_wr_en,
  output logic [7:0]  oam_wr_idx,
  output logic [7:0]  oam_wr_data
);

  localparam int unsigned SLOT_W = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned DLY_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLES_PER_BYTE - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(START_DELAY - 1);
  localparam logic [7:0]        IDX_LAST  = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        idx_q, idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              restart_q, restart_d;

  logic              trig_c;
  logic [7:0]        src_page_c;

  assign trig_c     = wr_en && (addr == REG_ADDR);
  // Echo RAM pages E0..FF alias work RAM C0..DF.
  assign src_page_c = (MIRROR_ECHO && (reg_q >= 8'hE0)) ? (reg_q - 8'h20) : reg_q;
  assign data_o     = reg_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      reg_q     <= 8'h00;
      idx_q     <= 8'h00;
      slot_q    <= '0;
      dly_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_q     <= reg_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      dly_q     <= dly_d;
      restart_q <= restart_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    dly_d       = dly_q;
    restart_d   = restart_q;
    dma_start   = 1'b0;
    dma_active  = 1'b0;
    dma_rd_req  = 1'b0;
    dma_rd_addr = 16'h0000;
    oam_wr_en   = 1'b0;
    oam_wr_idx  = 8'h00;
    oam_wr_data = 8'h00;

    case (state_q)
      S_IDLE: begin
      end
      S_DELAY: begin
        dma_start  = 1'b1;
        dma_active = restart_q;
        slot_d     = slot_q + SLOT_W'(1);
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (dly_q == DLY_LAST) begin
            state_d   = S_XFER;
            dly_d     = '0;
            restart_d = 1'b0;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
      end
      S_XFER: begin
        dma_active  = 1'b1;
        dma_rd_req  = 1'b1;
        dma_rd_addr = {src_page_c, idx_q};
        slot_d      = slot_q + SLOT_W'(1);
        if (slot_q == SLOT_LAST) begin
          slot_d      = '0;
          oam_wr_en   = 1'b1;
          oam_wr_idx  = idx_q;
          oam_wr_data = dma_rd_data;
          idx_d       = idx_q + 8'd1;
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A register write always wins; the write strobe above still fires this cycle.
    if (trig_c) begin
      reg_d     = data_i;
      state_d   = S_DELAY;
      idx_d     = 8'h00;
      slot_d    = '0;
      dly_d     = '0;
      restart_d = (state_q == S_XFER) ? 1'b1 : restart_q;
    end
  end

endmodule

// File: tb/tb_gb_oam_dma_engine.sv
// Bench for gb_oam_dma_engine: two instances (default parameters, and
// LEN=256/CPB=2/DELAY=2/no echo mirroring) share one CPU bus. A timing model
// predicts per-cycle status outputs; OAM writes go through a scoreboard queue.
module tb_gb_oam_dma_engine;

  localparam int NDUT = 2;

  function automatic int plen(int d); return (d == 0) ? 160 : 256; endfunction
  function automatic int pcpb(int d); return (d == 0) ? 4 : 2;     endfunction
  function automatic int psd(int d);  return (d == 0) ? 1 : 2;     endfunction
  function automatic bit pme(int d);  return (d == 0);             endfunction

  typedef struct {
    int          cyc;
    logic [7:0]  idx;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        wr_en;
  logic [7:0]  data_i;

  logic [7:0]  data_o      [NDUT];
  logic        dma_start   [NDUT];
  logic        dma_active  [NDUT];
  logic        dma_rd_req  [NDUT];
  logic [15:0] dma_rd_addr [NDUT];
  logic [7:0]  dma_rd_data [NDUT];
  logic        oam_wr_en   [NDUT];
  logic [7:0]  oam_wr_idx  [NDUT];
  logic [7:0]  oam_wr_data [NDUT];

  // Model state
  int          cyc;
  int          t0     [NDUT];
  bit          run_v  [NDUT];
  bit          carry  [NDUT];
  logic [7:0]  regv   [NDUT];
  exp_t        sbq    [NDUT][$];

  int n_cmp;
  int n_bad;

  function automatic logic [7:0] mem(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign dma_rd_data[0] = mem(dma_rd_addr[0]);
  assign dma_rd_data[1] = mem(dma_rd_addr[1]);

  gb_oam_dma_engine u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .data_i(data_i),
    .data_o(data_o[0]), .dma_start(dma_start[0]), .dma_active(dma_active[0]),
    .dma_rd_req(dma_rd_req[0]), .dma_rd_addr(dma_rd_addr[0]),
    .dma_rd_data(dma_rd_data[0]), .oam_wr_en(oam_wr_en[0]),
    .oam_wr_idx(oam_wr_idx[0]), .oam_wr_data(oam_wr_data[0])
  );

  gb_oam_dma_engine #(
    .XFER_LEN(256), .CYCLES_PER_BYTE(2), .START_DELAY(2), .MIRROR_ECHO(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .data_i(data_i),
    .data_o(data_o[1]), .dma_start(dma_start[1]), .dma_active(dma_active[1]),
    .dma_rd_req(dma_rd_req[1]), .dma_rd_addr(dma_rd_addr[1]),
    .dma_rd_data(dma_rd_data[1]), .oam_wr_en(oam_wr_en[1]),
    .oam_wr_idx(oam_wr_idx[1]), .oam_wr_data(oam_wr_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] src_page(int d, logic [7:0] r);
    if (pme(d) && r >= 8'hE0) return r - 8'h20;
    return r;
  endfunction

  // Sample point c is the negedge after posedge number c.
  function automatic bit in_dly(int d, int c);
    return run_v[d] && c >= t0[d] && c < t0[d] + psd(d) * pcpb(d);
  endfunction

  function automatic bit in_xfer(int d, int c);
    return run_v[d] && c >= t0[d] + psd(d) * pcpb(d) &&
           c < t0[d] + (psd(d) + plen(d)) * pcpb(d);
  endfunction

  // {start, active, rd_req, rd_addr, wr_en, data_o}
  function automatic logic [27:0] exp_vec(int d, int c);
    bit          dl, xf, wr;
    int          i;
    logic [15:0] a;
    dl = in_dly(d, c);
    xf = in_xfer(d, c);
    a  = 16'h0000;
    wr = 1'b0;
    if (xf) begin
      i  = (c - t0[d] - psd(d) * pcpb(d)) / pcpb(d);
      a  = {src_page(d, regv[d]), 8'(i)};
      wr = ((c + 1 - t0[d]) % pcpb(d)) == 0;
    end
    return {dl, xf | (dl & carry[d]), xf, a, wr, regv[d]};
  endfunction

  // Register write accepted at posedge t.
  task automatic model_trigger(int t, logic [7:0] v);
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      carry[d] = in_xfer(d, t - 1) || (in_dly(d, t - 1) && carry[d]);
      while (sbq[d].size() > 0 && sbq[d][sbq[d].size() - 1].cyc >= t)
        void'(sbq[d].pop_back());
      t0[d]   = t;
      run_v[d] = 1'b1;
      regv[d] = v;
      for (int i = 0; i < plen(d); i++) begin
        e.cyc  = t + (psd(d) + 1 + i) * pcpb(d) - 1;
        e.idx  = 8'(i);
        e.addr = {src_page(d, v), 8'(i)};
        e.data = mem(e.addr);
        sbq[d].push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      run_v[d] = 1'b0;
      carry[d] = 1'b0;
      regv[d]  = 8'h00;
      sbq[d].delete();
    end
  endtask

  // Monitor: per-cycle status check plus scoreboard pop on each OAM write.
  always @(negedge clk) begin
    logic [27:0] ev, av;
    exp_t        e;
    for (int d = 0; d < NDUT; d++) begin
      ev = exp_vec(d, cyc);
      av = {dma_start[d], dma_active[d], dma_rd_req[d], dma_rd_addr[d],
            oam_wr_en[d], data_o[d]};
      n_cmp++;
      if (av !== ev) begin
        n_bad++;
        $display("FAIL status dut%0d cyc %0d: got %h expected %h", d, cyc, av, ev);
      end
      if (oam_wr_en[d] === 1'b1) begin
        n_cmp++;
        if (sbq[d].size() == 0) begin
          n_bad++;
          $display("FAIL oam_write dut%0d cyc %0d: unexpected write idx %0d", d, cyc, oam_wr_idx[d]);
        end else begin
          e = sbq[d].pop_front();
          if (e.cyc != cyc || e.idx !== oam_wr_idx[d] || e.data !== oam_wr_data[d] ||
              e.addr !== dma_rd_addr[d]) begin
            n_bad++;
            $display("FAIL oam_write dut%0d: got cyc %0d idx %0d addr %h data %h expected cyc %0d idx %0d addr %h data %h",
                     d, cyc, oam_wr_idx[d], dma_rd_addr[d], oam_wr_data[d],
                     e.cyc, e.idx, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic cpu_write(logic [15:0] a, logic [7:0] v);
    @(negedge clk); #1;
    addr   = a;
    wr_en  = 1'b1;
    data_i = v;
    if (a == 16'hFF46 && !reset) model_trigger(cyc + 1, v);
    @(negedge clk); #1;
    wr_en  = 1'b0;
    addr   = 16'h8000;
    data_i = 8'($urandom);
  endtask

  task automatic pulse_reset(int hold);
    logic [7:0] z;
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      z = 8'h00;
      n_cmp++;
      if ({dma_start[d], dma_active[d], dma_rd_req[d], oam_wr_en[d]} !== 4'b0 ||
          dma_rd_addr[d] !== 16'h0000 || oam_wr_idx[d] !== z ||
          oam_wr_data[d] !== z || data_o[d] !== z) begin
        n_bad++;
        $display("FAIL async_reset dut%0d: got start %b active %b req %b addr %h wr %b idx %h data %h reg %h expected all zero",
                 d, dma_start[d], dma_active[d], dma_rd_req[d], dma_rd_addr[d],
                 oam_wr_en[d], oam_wr_idx[d], oam_wr_data[d], data_o[d]);
      end
    end
    repeat (hold) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          r;
    logic [15:0] oa;
    cyc    = 0;
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    addr   = 16'h0000;
    wr_en  = 1'b0;
    data_i = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Full run from work RAM page, then readback stays C1
    cpu_write(16'hFF46, 8'hC1);
    wait_cycles(700);

    // Echo page: mirrored on dut0, not on dut1
    cpu_write(16'hFF46, 8'hE3);
    wait_cycles(700);

    // Non-register writes ignored
    cpu_write(16'hFF47, 8'h55);
    cpu_write(16'h0046, 8'h77);
    wait_cycles(10);

    // Restart at byte 50 of dut0
    cpu_write(16'hFF46, 8'hC1);
    wait_cycles(202);
    cpu_write(16'hFF46, 8'hD0);
    wait_cycles(700);

    // Reset around byte 20, then a fresh trigger
    cpu_write(16'hFF46, 8'hC2);
    wait_cycles(82);
    pulse_reset(3);
    wait_cycles(20);
    cpu_write(16'hFF46, 8'hFE);
    wait_cycles(700);

    // Randomized triggers, stray writes and resets
    for (int k = 0; k < 30; k++) begin
      wait_cycles($urandom_range(0, 350));
      r = $urandom_range(0, 9);
      if (r < 7) begin
        cpu_write(16'hFF46, 8'($urandom));
      end else if (r < 9) begin
        oa = 16'($urandom);
        if (oa == 16'hFF46) oa = 16'hFF45;
        cpu_write(oa, 8'($urandom));
      end else begin
        pulse_reset($urandom_range(1, 4));
      end
    end
    wait_cycles(800);

    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (sbq[d].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut%0d: %0d writes outstanding, expected 0", d, sbq[d].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
